// File: rtl/int_ctrl_pkg.sv
// int_ctrl_pkg: state encoding and register offsets shared by the interrupt controller.
package int_ctrl_pkg;
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_SVC = 2'd2} state_t;
   localparam logic [15:0] OFS_PEND = 16'd0;
   localparam logic [15:0] OFS_EN = 16'd1;
   localparam logic [15:0] OFS_ACT = 16'd2;
endpackage

// File: rtl/int_ctrl_prio_enc.sv
// prio_enc: lowest-index-first priority encoder; index 0 wins.
module prio_enc #(
   parameter int N = 4
) (
   input  logic [N-1:0] in,
   output logic         valid,
   output logic [2:0]   idx
);
   always_comb begin
      idx = 3'd0;
      for (int i = N - 1; i >= 0; i--)
         if (in[i]) idx = 3'(i);
   end
   assign valid = |in;
endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: latches request pulses, masks them and hands the highest-priority
// pending source to the processor through an INTERRUPT/ACK/EOI handshake.
module int_ctrl
   import int_ctrl_pkg::*;
#(
   parameter int          NREQ      = 4,
   parameter logic [15:0] BASE_ADDR = 16'h0010
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NREQ-1:0] req,
   input  logic            int_ack,
   input  logic [15:0]     port_id,
   input  logic            write_strobe,
   input  logic [15:0]     out_port,
   output logic            interrupt,
   output logic [15:0]     rd_data
);
   localparam logic [15:0] A_PEND = BASE_ADDR + OFS_PEND;
   localparam logic [15:0] A_EN = BASE_ADDR + OFS_EN;
   localparam logic [15:0] A_ACT = BASE_ADDR + OFS_ACT;

   state_t          state;
   logic [NREQ-1:0] pending, enable, clr;
   logic [2:0]      active_id, sel_idx;
   logic            sel_valid, wr_pend, wr_en, wr_eoi, ack_clr;
   logic [15:0]     unused_data;

   assign unused_data = out_port;
   assign wr_pend = write_strobe && port_id == A_PEND;
   assign wr_en = write_strobe && port_id == A_EN;
   assign wr_eoi = write_strobe && port_id == A_ACT;
   assign ack_clr = state == ST_REQ && int_ack;
   // A same-cycle req is OR-ed in after the clear so that set always wins.
   assign clr = (wr_pend ? out_port[NREQ-1:0] : '0) |
                (ack_clr ? NREQ'(1) << active_id : '0);

   prio_enc #(.N(NREQ)) u_prio (
      .in(pending & enable),
      .valid(sel_valid),
      .idx(sel_idx)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending   <= '0;
         enable    <= '1;
         active_id <= 3'd0;
         state     <= ST_IDLE;
         interrupt <= 1'b0;
      end else begin
         pending <= (pending & ~clr) | req;
         if (wr_en) enable <= out_port[NREQ-1:0];
         case (state)
            ST_IDLE: if (sel_valid) begin
               active_id <= sel_idx;
               interrupt <= 1'b1;
               state     <= ST_REQ;
            end
            ST_REQ: if (int_ack) begin
               interrupt <= 1'b0;
               state     <= ST_SVC;
            end
            ST_SVC: if (wr_eoi) state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb
      rd_data = port_id == A_PEND ? 16'(pending) :
                port_id == A_EN   ? 16'(enable) :
                port_id == A_ACT  ? {state != ST_IDLE, 12'b0, active_id} : 16'h0000;
endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed scoreboard bench for int_ctrl.
module tb_int_ctrl;
   localparam logic [15:0] BA = 16'h0010;
   logic        clk = 1'b0, reset = 1'b1, int_ack = 1'b0, write_strobe = 1'b0;
   logic [3:0]  req = 4'd0;
   logic [15:0] port_id = 16'h0, out_port = 16'h0, rd_data;
   logic        interrupt;
   int          tests = 0, fails = 0;

   typedef struct {
      string       tag;
      logic [15:0] v;
   } exp_t;
   exp_t sb[$];

   int_ctrl #(.NREQ(4), .BASE_ADDR(BA)) dut (
      .clk(clk), .reset(reset), .req(req), .int_ack(int_ack), .port_id(port_id),
      .write_strobe(write_strobe), .out_port(out_port), .interrupt(interrupt),
      .rd_data(rd_data)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(string tag, logic [15:0] v);
      exp_t e;
      e.tag = tag;
      e.v = v;
      sb.push_back(e);
   endtask

   task automatic pop_chk(logic [15:0] obs);
      exp_t e;
      e = sb.pop_front();
      tests++;
      assert (obs === e.v)
      else begin
         fails++;
         $error("FAIL %s: got %h expected %h", e.tag, obs, e.v);
      end
   endtask

   task automatic chk_irq(string tag, logic v);
      push(tag, {15'b0, v});
      pop_chk({15'b0, interrupt});
   endtask

   task automatic chk_rd(string tag, logic [15:0] addr, logic [15:0] v);
      push(tag, v);
      port_id = addr;
      #1;
      pop_chk(rd_data);
      port_id = 16'h0;
   endtask

   task automatic wr(logic [15:0] addr, logic [15:0] data);
      port_id = addr;
      out_port = data;
      write_strobe = 1'b1;
      tick();
      write_strobe = 1'b0;
      port_id = 16'h0;
      out_port = 16'h0;
   endtask

   task automatic ack();
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
   endtask

   initial begin
      tick();
      tick();
      reset = 1'b0;
      chk_irq("rst_irq", 1'b0);
      chk_rd("rst_pend", BA, 16'h0000);
      chk_rd("rst_en", BA + 1, 16'h000F);
      chk_rd("rst_act", BA + 2, 16'h0000);
      chk_rd("unmapped", 16'h0013, 16'h0000);
      // single source: pending at n+1, interrupt at n+2
      req = 4'b0001;
      tick();
      req = 4'b0000;
      chk_irq("t1_irq_n1", 1'b0);
      chk_rd("t1_pend", BA, 16'h0001);
      tick();
      chk_irq("t1_irq_n2", 1'b1);
      chk_rd("t1_act_req", BA + 2, 16'h8000);
      ack();
      chk_irq("t1_irq_ack", 1'b0);
      chk_rd("t1_pend_ack", BA, 16'h0000);
      chk_rd("t1_act_svc", BA + 2, 16'h8000);
      wr(BA + 2, 16'hFFFF);
      chk_rd("t1_act_eoi", BA + 2, 16'h0000);
      // priority: 1 before 2
      req = 4'b0110;
      tick();
      req = 4'b0000;
      tick();
      chk_irq("t2_irq", 1'b1);
      chk_rd("t2_act1", BA + 2, 16'h8001);
      ack();
      chk_rd("t2_pend", BA, 16'h0004);
      wr(BA + 2, 16'h0);
      chk_irq("t2_irq_eoi", 1'b0);
      tick();
      chk_irq("t2_irq2", 1'b1);
      chk_rd("t2_act2", BA + 2, 16'h8002);
      ack();
      wr(BA + 2, 16'h0);
      // masking
      wr(BA + 1, 16'h000E);
      req = 4'b0001;
      tick();
      req = 4'b0000;
      tick();
      tick();
      chk_irq("t3_masked", 1'b0);
      chk_rd("t3_pend", BA, 16'h0001);
      chk_rd("t3_en", BA + 1, 16'h000E);
      wr(BA + 1, 16'h000F);
      chk_irq("t3_irq_wr", 1'b0);
      tick();
      chk_irq("t3_irq_unmask", 1'b1);
      chk_rd("t3_act", BA + 2, 16'h8000);
      ack();
      // no nesting during SVC
      req = 4'b1000;
      tick();
      req = 4'b0000;
      tick();
      tick();
      chk_irq("t4_svc_hold", 1'b0);
      chk_rd("t4_pend", BA, 16'h0008);
      wr(BA + 2, 16'h0);
      chk_irq("t4_eoi_edge", 1'b0);
      tick();
      chk_irq("t4_irq", 1'b1);
      chk_rd("t4_act3", BA + 2, 16'h8003);
      wr(BA + 2, 16'h0);
      chk_irq("t4_eoi_in_req", 1'b1);
      ack();
      wr(BA + 2, 16'h0);
      // set wins over write-1-to-clear
      port_id = BA;
      out_port = 16'h000F;
      write_strobe = 1'b1;
      req = 4'b0010;
      tick();
      write_strobe = 1'b0;
      req = 4'b0000;
      out_port = 16'h0;
      chk_rd("t5_w1c_setwins", BA, 16'h0002);
      tick();
      chk_irq("t5_irq", 1'b1);
      chk_rd("t5_act1", BA + 2, 16'h8001);
      // set wins over ack clear
      int_ack = 1'b1;
      req = 4'b0010;
      tick();
      int_ack = 1'b0;
      req = 4'b0000;
      chk_irq("t5_irq_ack", 1'b0);
      chk_rd("t5_ack_setwins", BA, 16'h0002);
      ack();
      chk_rd("t5_ack_in_svc", BA + 2, 16'h8001);
      wr(BA + 2, 16'h0);
      tick();
      chk_irq("t5_irq_again", 1'b1);
      // enable change in REQ keeps interrupt; async reset
      wr(BA + 1, 16'h0003);
      chk_irq("t6_en_in_req", 1'b1);
      chk_rd("t6_en", BA + 1, 16'h0003);
      #2;
      reset = 1'b1;
      #1;
      chk_irq("t6_async_irq", 1'b0);
      chk_rd("t6_async_pend", BA, 16'h0000);
      chk_rd("t6_async_en", BA + 1, 16'h000F);
      chk_rd("t6_async_act", BA + 2, 16'h0000);
      tick();
      reset = 1'b0;
      tick();
      chk_irq("t6_post_rst", 1'b0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
